// File: rtl/lfsr_axi_master_pkg.sv
// Shared definitions for the LFSR AXI-Lite initiator: register map, ctrl bits, response codes, FSM encodings.
package lfsr_axi_master_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [ADDR_W-1:0] ADDR_CTRL = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_SEED = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_TAPS = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_DATA = 4'hC;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_LOAD_BIT = 1;

    localparam logic [DATA_W-1:0] CTRL_EN   = DATA_W'(1 << CTRL_EN_BIT);
    localparam logic [DATA_W-1:0] CTRL_LOAD = DATA_W'(1 << CTRL_LOAD_BIT);
    localparam logic [DATA_W-1:0] CTRL_STOP = '0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_SEED,
        ST_WR_TAPS,
        ST_WR_LOAD,
        ST_WR_EN,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_OUT,
        ST_WR_STOP
    } state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_RESP
    } wr_state_t;

    function automatic wr_req_t mk_req(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        wr_req_t r;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/lfsr_axi_master_if.sv
// AXI-Lite bus between the initiator and the LFSR peripheral (4-bit address, 8-bit data).
interface lfsr_axi_master_if;
    import lfsr_axi_master_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rvalid
    );

endinterface

// File: rtl/lfsr_axi_master_wr_txn.sv
// Single AXI-Lite write engine: issues AW and W together, retires each independently, then waits for B.
module lfsr_axi_master_wr_txn
    import lfsr_axi_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              done,
    output logic [1:0]        resp
);

    wr_state_t         state_q, state_d;
    logic              aw_ok_q, aw_ok_d;
    logic              w_ok_q, w_ok_d;
    logic              awvalid_d, wvalid_d, bready_d, done_d;
    logic [ADDR_W-1:0] awaddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [1:0]        resp_d;
    logic              aw_hs_c, w_hs_c;

    assign aw_hs_c = awvalid & awready;
    assign w_hs_c  = wvalid & wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WR_IDLE;
            aw_ok_q <= 1'b0;
            w_ok_q  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            done    <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            resp    <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            aw_ok_q <= aw_ok_d;
            w_ok_q  <= w_ok_d;
            awvalid <= awvalid_d;
            wvalid  <= wvalid_d;
            bready  <= bready_d;
            done    <= done_d;
            awaddr  <= awaddr_d;
            wdata   <= wdata_d;
            resp    <= resp_d;
        end
    end

    // bready only after both AW and W have been accepted, in whichever order they complete
    always_comb begin
        state_d   = state_q;
        aw_ok_d   = aw_ok_q;
        w_ok_d    = w_ok_q;
        awvalid_d = awvalid;
        wvalid_d  = wvalid;
        bready_d  = bready;
        done_d    = 1'b0;
        awaddr_d  = awaddr;
        wdata_d   = wdata;
        resp_d    = resp;
        unique case (state_q)
            WR_IDLE: begin
                if (go) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = addr;
                    wdata_d   = data;
                    aw_ok_d   = 1'b0;
                    w_ok_d    = 1'b0;
                    state_d   = WR_ADDR;
                end
            end
            WR_ADDR: begin
                if (aw_hs_c) begin
                    awvalid_d = 1'b0;
                    aw_ok_d   = 1'b1;
                end
                if (w_hs_c) begin
                    wvalid_d = 1'b0;
                    w_ok_d   = 1'b1;
                end
                if ((aw_ok_q | aw_hs_c) && (w_ok_q | w_hs_c)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    resp_d   = bresp;
                    state_d  = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

endmodule

// File: rtl/lfsr_axi_master.sv
// AXI-Lite initiator that programs the LFSR peripheral, streams CMD_COUNT samples out, then stops it.
module lfsr_axi_master
    import lfsr_axi_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_start,
    input  logic [DATA_W-1:0] cmd_seed,
    input  logic [DATA_W-1:0] cmd_taps,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    input  logic              smp_ready,
    lfsr_axi_master_if.master m_axi
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] taps_q, taps_d;
    wr_req_t           req_q, req_d;
    logic              go_q, go_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              busy_d, done_d, err_d, smp_valid_d;
    logic [DATA_W-1:0] smp_data_d;
    logic              wr_done;
    logic [1:0]        wr_resp;

    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.rready  = rready_q;

    lfsr_axi_master_wr_txn u_wr (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go_q),
        .addr    (req_q.addr),
        .data    (req_q.data),
        .awaddr  (m_axi.awaddr),
        .awvalid (m_axi.awvalid),
        .awready (m_axi.awready),
        .wdata   (m_axi.wdata),
        .wvalid  (m_axi.wvalid),
        .wready  (m_axi.wready),
        .bresp   (m_axi.bresp),
        .bvalid  (m_axi.bvalid),
        .bready  (m_axi.bready),
        .done    (wr_done),
        .resp    (wr_resp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            taps_q    <= '0;
            req_q     <= '0;
            go_q      <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            smp_valid <= 1'b0;
            smp_data  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            taps_q    <= taps_d;
            req_q     <= req_d;
            go_q      <= go_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            smp_valid <= smp_valid_d;
            smp_data  <= smp_data_d;
        end
    end

    // Each write state launches the next write when the engine reports its B handshake
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        taps_d      = taps_q;
        req_d       = req_q;
        go_d        = 1'b0;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        araddr_d    = araddr_q;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = err;
        smp_valid_d = smp_valid;
        smp_data_d  = smp_data;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_start && !done) begin
                    taps_d  = cmd_taps;
                    cnt_d   = cmd_count;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    go_d    = 1'b1;
                    req_d   = mk_req(ADDR_SEED, cmd_seed);
                    state_d = ST_WR_SEED;
                end
            end
            ST_WR_SEED: begin
                if (wr_done) begin
                    go_d    = 1'b1;
                    req_d   = mk_req(ADDR_TAPS, taps_q);
                    state_d = ST_WR_TAPS;
                end
            end
            ST_WR_TAPS: begin
                if (wr_done) begin
                    go_d    = 1'b1;
                    req_d   = mk_req(ADDR_CTRL, CTRL_LOAD);
                    state_d = ST_WR_LOAD;
                end
            end
            ST_WR_LOAD: begin
                if (wr_done) begin
                    go_d    = 1'b1;
                    req_d   = mk_req(ADDR_CTRL, CTRL_EN);
                    state_d = ST_WR_EN;
                end
            end
            ST_WR_EN: begin
                if (wr_done) begin
                    if (cnt_q == '0) begin
                        go_d    = 1'b1;
                        req_d   = mk_req(ADDR_CTRL, CTRL_STOP);
                        state_d = ST_WR_STOP;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = ADDR_DATA;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi.rvalid) begin
                    rready_d    = 1'b0;
                    smp_data_d  = m_axi.rdata;
                    smp_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            // The next AR waits for the hand-off, so backpressure stalls the bus only
            ST_OUT: begin
                if (smp_ready) begin
                    smp_valid_d = 1'b0;
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        go_d    = 1'b1;
                        req_d   = mk_req(ADDR_CTRL, CTRL_STOP);
                        state_d = ST_WR_STOP;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = ADDR_DATA;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_STOP: begin
                if (wr_done) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_done && (wr_resp != RESP_OKAY)) begin
            err_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_lfsr_axi_master.sv
// Directed bench for lfsr_axi_master against a behavioural LFSR slave with programmable ready delays.
module tb_lfsr_axi_master;
    import lfsr_axi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [7:0]  cmd_seed = 8'h00;
    logic [7:0]  cmd_taps = 8'h00;
    logic [15:0] cmd_count = 16'h0000;
    logic        busy, done, err, smp_valid;
    logic [7:0]  smp_data;
    logic        smp_ready = 1'b1;

    lfsr_axi_master_if axi ();

    lfsr_axi_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_start (cmd_start),
        .cmd_seed  (cmd_seed),
        .cmd_taps  (cmd_taps),
        .cmd_count (cmd_count),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .m_axi     (axi)
    );

    always #5 clk = ~clk;

    // Slave knobs
    int         aw_delay = 0;
    int         w_delay  = 0;
    logic [3:0] err_addr = 4'hF;

    int         aw_cnt, w_cnt;
    logic       aw_got, w_got, ar_got;
    logic [3:0] aw_a;
    logic [7:0] w_d;
    logic [7:0] s_ctrl, s_seed, s_taps, s_lfsr;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v, input logic [7:0] t);
        return {v[6:0], ^(v & t)};
    endfunction

    // Behavioural LFSR peripheral
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rdata <= 8'h00;
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_a <= 4'h0; w_d <= 8'h00;
            s_ctrl <= 8'h00; s_seed <= 8'h00; s_taps <= 8'h00; s_lfsr <= 8'h00;
        end else begin
            axi.awready <= 1'b0;
            if (axi.awvalid && axi.awready) begin
                aw_got <= 1'b1; aw_a <= axi.awaddr;
            end else if (axi.awvalid && !aw_got) begin
                if (aw_cnt >= aw_delay) begin axi.awready <= 1'b1; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end
            axi.wready <= 1'b0;
            if (axi.wvalid && axi.wready) begin
                w_got <= 1'b1; w_d <= axi.wdata;
            end else if (axi.wvalid && !w_got) begin
                if (w_cnt >= w_delay) begin axi.wready <= 1'b1; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !axi.bvalid) begin
                axi.bvalid <= 1'b1;
                axi.bresp  <= (aw_a == err_addr) ? 2'b10 : 2'b00;
                aw_got <= 1'b0; w_got <= 1'b0;
                case (aw_a)
                    4'h0: begin s_ctrl <= w_d; if (w_d[1]) s_lfsr <= s_seed; end
                    4'h4: s_seed <= w_d;
                    4'h8: s_taps <= w_d;
                    default: ;
                endcase
            end else if (s_ctrl[0]) begin
                s_lfsr <= lfsr_step(s_lfsr, s_taps);
            end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            axi.arready <= 1'b0;
            if (axi.arvalid && axi.arready) ar_got <= 1'b1;
            else if (axi.arvalid && !ar_got) axi.arready <= 1'b1;
            if (ar_got && !axi.rvalid) begin
                axi.rvalid <= 1'b1; axi.rdata <= s_lfsr; ar_got <= 1'b0;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // Bus monitor
    logic [3:0] aw_log[$];
    logic [7:0] w_log[$], r_log[$], s_log[$];
    int ar_n, done_n, asym_n, ar_smp_n, overlap_n, cyc, t_aw, t_smp;

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (axi.awvalid && axi.awready) begin aw_log.push_back(axi.awaddr); t_aw = cyc; end
            if (axi.wvalid && axi.wready) w_log.push_back(axi.wdata);
            if (axi.arvalid && axi.arready) ar_n++;
            if (axi.rvalid && axi.rready) r_log.push_back(axi.rdata);
            if (smp_valid && smp_ready) begin s_log.push_back(smp_data); t_smp = cyc; end
            if (done) done_n++;
            if (axi.awvalid != axi.wvalid) asym_n++;
            if (axi.arvalid && smp_valid) ar_smp_n++;
            if ((axi.awvalid || axi.wvalid || axi.bready) && (axi.arvalid || axi.rready)) overlap_n++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        aw_log.delete(); w_log.delete(); r_log.delete(); s_log.delete();
        ar_n = 0; done_n = 0; asym_n = 0; ar_smp_n = 0; overlap_n = 0; t_aw = 0; t_smp = 0;
    endtask

    task automatic start(input logic [7:0] s, input logic [7:0] t, input logic [15:0] c);
        @(negedge clk);
        cmd_seed = s; cmd_taps = t; cmd_count = c; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    // Expected write stream: seed, taps, load, enable, stop
    task automatic check_seq(input string tag, input logic [7:0] s, input logic [7:0] t);
        logic [3:0] ea[5];
        logic [7:0] ed[5];
        int got;
        ea = '{4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
        ed = '{s, t, 8'h02, 8'h01, 8'h00};
        check({tag, "_naw"}, aw_log.size(), 5);
        check({tag, "_nw"}, w_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            got = (i < aw_log.size() && i < w_log.size()) ? int'({aw_log[i], w_log[i]}) : -1;
            check($sformatf("%s_wr%0d", tag, i), got, int'({ea[i], ed[i]}));
        end
    endtask

    initial begin
        logic [7:0] d0;
        int k, bad;
        repeat (3) @(negedge clk);
        check("rst_ctl", int'({busy, done, err, smp_valid}), 0);
        check("rst_bus", int'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 0);
        check("rst_data", int'({axi.awaddr, axi.wdata, axi.araddr, smp_data}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // count=0: five writes, no reads; start coincident with done is dropped
        clear_logs();
        start(8'h5A, 8'hB8, 16'd0);
        check("t1_busy", int'(busy), 1);
        wait_done(300);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        check("t1_done_pulse", int'(done), 0);
        repeat (10) @(negedge clk);
        check_seq("t1", 8'h5A, 8'hB8);
        check("t1_ar", ar_n, 0);
        check("t1_smp", s_log.size(), 0);
        check("t1_done_n", done_n, 1);
        check("t1_err_busy", int'({err, busy}), 0);
        check("t1_asym", asym_n, 0);

        // four samples; a start while busy is ignored
        clear_logs();
        start(8'h19, 8'hB8, 16'd4);
        repeat (6) @(negedge clk);
        check("t2_busy", int'(busy), 1);
        cmd_seed = 8'h77; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done(600);
        repeat (3) @(negedge clk);
        check_seq("t2", 8'h19, 8'hB8);
        check("t2_ar", ar_n, 4);
        check("t2_nsmp", s_log.size(), 4);
        check("t2_nr", r_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < s_log.size() && i < r_log.size()) begin
                check($sformatf("t2_smp%0d", i), int'(s_log[i]), int'(r_log[i]));
                check($sformatf("t2_nz%0d", i), int'(s_log[i] != 8'h00), 1);
            end
        end
        check("t2_stop_after_smp", int'(t_aw > t_smp), 1);
        check("t2_overlap", overlap_n, 0);
        check("t2_done_n", done_n, 1);

        // backpressure: sample 1 of 3 held for 20 cycles
        clear_logs();
        smp_ready = 1'b0;
        start(8'h19, 8'hB8, 16'd3);
        k = 0;
        while (!smp_valid && k < 300) begin @(negedge clk); k++; end
        check("t3_smp_seen", int'(smp_valid), 1);
        d0 = smp_data;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!smp_valid || smp_data != d0) bad++;
        end
        check("t3_stable", bad, 0);
        check("t3_ar_stall", ar_n, 1);
        smp_ready = 1'b1;
        wait_done(600);
        check("t3_nsmp", s_log.size(), 3);
        check("t3_smp0", (s_log.size() > 0) ? int'(s_log[0]) : -1, int'(d0));
        check("t3_ar_smp", ar_smp_n, 0);

        // skewed AW/W readiness, both directions
        clear_logs();
        aw_delay = 3; w_delay = 0;
        start(8'h3C, 8'hB8, 16'd0);
        wait_done(400);
        check_seq("t4a", 8'h3C, 8'hB8);
        check("t4a_asym", int'(asym_n > 0), 1);
        clear_logs();
        aw_delay = 0; w_delay = 3;
        start(8'h8E, 8'hB8, 16'd0);
        wait_done(400);
        check_seq("t4b", 8'h8E, 8'hB8);
        check("t4b_asym", int'(asym_n > 0), 1);
        w_delay = 0;

        // SLVERR on the taps write: err sticky, sequence completes, next start clears it
        clear_logs();
        err_addr = 4'h8;
        start(8'hA5, 8'hB8, 16'd2);
        wait_done(600);
        check("t5_err", int'(err), 1);
        check("t5_nsmp", s_log.size(), 2);
        check_seq("t5", 8'hA5, 8'hB8);
        repeat (5) @(negedge clk);
        check("t5_err_sticky", int'(err), 1);
        err_addr = 4'hF;
        start(8'h11, 8'hB8, 16'd0);
        check("t5_err_clr", int'(err), 0);
        wait_done(300);
        check("t5_err_after", int'(err), 0);

        // reset while an AR is outstanding
        repeat (2) @(negedge clk);
        clear_logs();
        start(8'h19, 8'hB8, 16'd3);
        k = 0;
        while (!axi.arvalid && k < 300) begin @(negedge clk); k++; end
        check("t6_arvalid", int'(axi.arvalid), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctl", int'({busy, done, err, smp_valid, smp_data}), 0);
        check("t6_rst_bus", int'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        start(8'hC3, 8'hB8, 16'd0);
        wait_done(300);
        repeat (2) @(negedge clk);
        check_seq("t6", 8'hC3, 8'hB8);
        check("t6_done_n", done_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
